// File: rtl/lcd_timing_monitor.sv
// Receive-side monitor for a parallel RGB565 LCD link: measures H/V timing,
// tracks lock, and re-emits the pixel stream with SOF/EOL markers and a frame checksum.

module lcd_timing_monitor #(
    parameter int CNT_W       = 12,
    parameter int HS_POL      = 0,
    parameter int VS_POL      = 0,
    parameter int LOCK_FRAMES = 3,
    parameter int TIMEOUT     = 4095
) (
    input  logic             PixelClk,
    input  logic             RST,
    input  logic             LCD_DE,
    input  logic             LCD_HSYNC,
    input  logic             LCD_VSYNC,
    input  logic [4:0]       LCD_R,
    input  logic [5:0]       LCD_G,
    input  logic [4:0]       LCD_B,
    output logic             PIX_VALID,
    output logic [15:0]      PIX_DATA,
    output logic             PIX_SOF,
    output logic             PIX_EOL,
    output logic [CNT_W-1:0] H_TOTAL,
    output logic [CNT_W-1:0] H_ACTIVE,
    output logic [CNT_W-1:0] V_TOTAL,
    output logic [CNT_W-1:0] V_ACTIVE,
    output logic [15:0]      FRAME_SUM,
    output logic             MEAS_VALID,
    output logic             LOCKED
);

    typedef enum logic [1:0] {IDLE, MEASURE, TRACK, LOCK} state_t;
    localparam int KEY_W = 4 * CNT_W;

    state_t             state_q, state_d;
    logic               de1_q, de1_d, hs1_q, hs1_d, vs1_q, vs1_d;
    logic               de2_q, de2_d, hs2_q, hs2_d, vs2_q, vs2_d;
    logic [15:0]        rgb1_q, rgb1_d, rgb2_q, rgb2_d;
    logic [CNT_W-1:0]   h_cnt_q, h_cnt_d, de_run_q, de_run_d;
    logic [CNT_W-1:0]   line_cnt_q, line_cnt_d, act_lines_q, act_lines_d;
    logic [15:0]        sum_q, sum_d, frame_sum_q, frame_sum_d;
    logic [CNT_W-1:0]   h_total_q, h_total_d, h_active_q, h_active_d;
    logic [CNT_W-1:0]   v_total_q, v_total_d, v_active_q, v_active_d;
    logic [CNT_W-1:0]   stable_q, stable_d;
    logic [KEY_W-1:0]   ref_q, ref_d, new_key;
    logic               hs_seen_q, hs_seen_d, sof_pend_q, sof_pend_d;
    logic               meas_valid_q, meas_valid_d, locked_q, locked_d;
    logic [CNT_W-1:0]   line_end, act_end;
    logic [15:0]        sum_end;
    logic               hs_lead, vs_lead, de_fall, timeout, pix_on;

    assign hs_lead = hs1_q & ~hs2_q;
    assign vs_lead = vs1_q & ~vs2_q;
    assign de_fall = de2_q & ~de1_q;
    assign timeout = (h_cnt_q >= CNT_W'(TIMEOUT));
    assign pix_on  = (state_q != IDLE);

    // Measurement counters, frame-boundary capture and the lock FSM next state.
    // Events coinciding with vs_lead are folded into the frame that is ending.
    always_comb begin
        de1_d        = LCD_DE;
        hs1_d        = (LCD_HSYNC == 1'(HS_POL));
        vs1_d        = (LCD_VSYNC == 1'(VS_POL));
        rgb1_d       = {LCD_R, LCD_G, LCD_B};
        de2_d        = de1_q;
        hs2_d        = hs1_q;
        vs2_d        = vs1_q;
        rgb2_d       = rgb1_q;
        h_cnt_d      = h_cnt_q;
        hs_seen_d    = hs_seen_q;
        de_run_d     = de_run_q;
        h_total_d    = h_total_q;
        h_active_d   = h_active_q;
        v_total_d    = v_total_q;
        v_active_d   = v_active_q;
        frame_sum_d  = frame_sum_q;
        meas_valid_d = 1'b0;
        state_d      = state_q;
        ref_d        = ref_q;
        stable_d     = stable_q;
        sof_pend_d   = sof_pend_q;

        line_end = line_cnt_q + CNT_W'(hs_lead);
        act_end  = act_lines_q + CNT_W'(de_fall);
        sum_end  = sum_q + (de1_q ? rgb1_q : 16'd0);

        if (hs_lead) begin
            h_cnt_d   = '0;
            hs_seen_d = 1'b1;
            if (hs_seen_q) h_total_d = h_cnt_q + CNT_W'(1);
        end else if (h_cnt_q != '1) begin
            h_cnt_d = h_cnt_q + CNT_W'(1);
        end

        if (de1_q && de_run_q != '1) de_run_d = de_run_q + CNT_W'(1);
        if (de_fall) begin
            h_active_d = de_run_q;
            de_run_d   = '0;
        end

        line_cnt_d  = line_end;
        act_lines_d = act_end;
        sum_d       = sum_end;
        new_key     = {h_total_d, h_active_d, line_end, act_end};

        if (PIX_VALID) sof_pend_d = 1'b0;

        if (vs_lead) begin
            line_cnt_d  = '0;
            act_lines_d = '0;
            sum_d       = '0;
            sof_pend_d  = 1'b1;
        end

        if (vs_lead && !timeout) begin
            if (state_q != IDLE) begin
                v_total_d    = line_end;
                v_active_d   = act_end;
                frame_sum_d  = sum_end;
                meas_valid_d = 1'b1;
            end
            case (state_q)
                IDLE: state_d = MEASURE;
                MEASURE: begin
                    ref_d    = new_key;
                    stable_d = CNT_W'(1);
                    state_d  = TRACK;
                end
                TRACK: begin
                    if (new_key == ref_q) begin
                        stable_d = stable_q + CNT_W'(1);
                        if (stable_q + CNT_W'(1) >= CNT_W'(LOCK_FRAMES)) state_d = LOCK;
                    end else begin
                        ref_d    = new_key;
                        stable_d = CNT_W'(1);
                    end
                end
                LOCK: begin
                    if (new_key != ref_q) begin
                        ref_d    = new_key;
                        stable_d = CNT_W'(1);
                        state_d  = TRACK;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // Losing HSYNC abandons tracking; captured measurements are left intact.
        if (timeout) begin
            state_d    = IDLE;
            stable_d   = '0;
            hs_seen_d  = 1'b0;
            sof_pend_d = 1'b0;
        end

        locked_d = (state_d == LOCK);
    end

    always_ff @(posedge PixelClk) begin
        if (RST) begin
            state_q      <= IDLE;
            de1_q        <= 1'b0;
            hs1_q        <= 1'b0;
            vs1_q        <= 1'b0;
            rgb1_q       <= '0;
            de2_q        <= 1'b0;
            hs2_q        <= 1'b0;
            vs2_q        <= 1'b0;
            rgb2_q       <= '0;
            h_cnt_q      <= '0;
            hs_seen_q    <= 1'b0;
            de_run_q     <= '0;
            line_cnt_q   <= '0;
            act_lines_q  <= '0;
            sum_q        <= '0;
            h_total_q    <= '0;
            h_active_q   <= '0;
            v_total_q    <= '0;
            v_active_q   <= '0;
            frame_sum_q  <= '0;
            meas_valid_q <= 1'b0;
            locked_q     <= 1'b0;
            ref_q        <= '0;
            stable_q     <= '0;
            sof_pend_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            de1_q        <= de1_d;
            hs1_q        <= hs1_d;
            vs1_q        <= vs1_d;
            rgb1_q       <= rgb1_d;
            de2_q        <= de2_d;
            hs2_q        <= hs2_d;
            vs2_q        <= vs2_d;
            rgb2_q       <= rgb2_d;
            h_cnt_q      <= h_cnt_d;
            hs_seen_q    <= hs_seen_d;
            de_run_q     <= de_run_d;
            line_cnt_q   <= line_cnt_d;
            act_lines_q  <= act_lines_d;
            sum_q        <= sum_d;
            h_total_q    <= h_total_d;
            h_active_q   <= h_active_d;
            v_total_q    <= v_total_d;
            v_active_q   <= v_active_d;
            frame_sum_q  <= frame_sum_d;
            meas_valid_q <= meas_valid_d;
            locked_q     <= locked_d;
            ref_q        <= ref_d;
            stable_q     <= stable_d;
            sof_pend_q   <= sof_pend_d;
        end
    end

    assign PIX_VALID  = de2_q & pix_on;
    assign PIX_DATA   = pix_on ? rgb2_q : 16'd0;
    assign PIX_EOL    = de_fall & pix_on;
    assign PIX_SOF    = PIX_VALID & sof_pend_q;
    assign H_TOTAL    = h_total_q;
    assign H_ACTIVE   = h_active_q;
    assign V_TOTAL    = v_total_q;
    assign V_ACTIVE   = v_active_q;
    assign FRAME_SUM  = frame_sum_q;
    assign MEAS_VALID = meas_valid_q;
    assign LOCKED     = locked_q;

endmodule

// File: tb/tb_lcd_timing_monitor.sv
// Scoreboard bench for lcd_timing_monitor: a reduced-size raster with lock, bad frame,
// HSYNC loss and mid-frame reset, checking pixel stream and per-frame measurements.

module tb_lcd_timing_monitor;

    localparam int CNT_W  = 12;
    localparam int TMO    = 200;
    localparam int LF     = 3;
    localparam int HT     = 40;
    localparam int DS     = 8;
    localparam int VT     = 12;
    localparam int VSTART = 2;
    localparam int VA     = 8;

    logic PixelClk = 1'b0;
    logic RST, LCD_DE, LCD_HSYNC, LCD_VSYNC;
    logic [4:0] LCD_R, LCD_B;
    logic [5:0] LCD_G;
    logic PIX_VALID, PIX_SOF, PIX_EOL, MEAS_VALID, LOCKED;
    logic [15:0] PIX_DATA, FRAME_SUM;
    logic [CNT_W-1:0] H_TOTAL, H_ACTIVE, V_TOTAL, V_ACTIVE;

    lcd_timing_monitor #(.CNT_W(CNT_W), .HS_POL(0), .VS_POL(0),
                         .LOCK_FRAMES(LF), .TIMEOUT(TMO)) dut (
        .PixelClk(PixelClk), .RST(RST), .LCD_DE(LCD_DE), .LCD_HSYNC(LCD_HSYNC),
        .LCD_VSYNC(LCD_VSYNC), .LCD_R(LCD_R), .LCD_G(LCD_G), .LCD_B(LCD_B),
        .PIX_VALID(PIX_VALID), .PIX_DATA(PIX_DATA), .PIX_SOF(PIX_SOF), .PIX_EOL(PIX_EOL),
        .H_TOTAL(H_TOTAL), .H_ACTIVE(H_ACTIVE), .V_TOTAL(V_TOTAL), .V_ACTIVE(V_ACTIVE),
        .FRAME_SUM(FRAME_SUM), .MEAS_VALID(MEAS_VALID), .LOCKED(LOCKED));

    always #5 PixelClk = ~PixelClk;

    int cyc = 0;
    always @(posedge PixelClk) cyc <= cyc + 1;

    typedef struct {logic [15:0] data; logic sof; logic eol; int at;} pix_t;
    typedef struct {logic [11:0] ht, ha, vt, va; logic [15:0] sum; logic lk; int at;} meas_t;
    pix_t  pixQ[$];
    meas_t measQ[$];

    int vectors = 0;
    int miscompares = 0;
    bit monOn = 1'b0;

    int expState = 0;
    bit stale = 1'b0;
    logic [47:0] refKey = '0;
    int stable = 0;
    logic [15:0] curSum = '0;
    int curHact = 0;
    bit sofPending = 1'b0;
    int lastHsCyc = 0;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic checkZero(input string where);
        checkOutput({where, ".PIX_VALID"}, 32'(PIX_VALID), 0);
        checkOutput({where, ".PIX_DATA"}, 32'(PIX_DATA), 0);
        checkOutput({where, ".PIX_SOF"}, 32'(PIX_SOF), 0);
        checkOutput({where, ".PIX_EOL"}, 32'(PIX_EOL), 0);
        checkOutput({where, ".H_TOTAL"}, 32'(H_TOTAL), 0);
        checkOutput({where, ".H_ACTIVE"}, 32'(H_ACTIVE), 0);
        checkOutput({where, ".V_TOTAL"}, 32'(V_TOTAL), 0);
        checkOutput({where, ".V_ACTIVE"}, 32'(V_ACTIVE), 0);
        checkOutput({where, ".FRAME_SUM"}, 32'(FRAME_SUM), 0);
        checkOutput({where, ".MEAS_VALID"}, 32'(MEAS_VALID), 0);
        checkOutput({where, ".LOCKED"}, 32'(LOCKED), 0);
    endtask

    // Expected behaviour at a VSYNC leading edge: close out the frame just driven
    task automatic modelVsEdge();
        meas_t m;
        logic [47:0] key;
        bit push;
        key = {12'(HT), 12'(curHact), 12'(VT), 12'(VA)};
        m.ht = 12'(HT); m.ha = 12'(curHact); m.vt = 12'(VT); m.va = 12'(VA);
        m.sum = curSum; m.at = cyc + 2;
        push = 1'b0;
        if (stale) begin
            stale = 1'b0;
        end else begin
            case (expState)
                0: expState = 1;
                1: begin refKey = key; stable = 1; expState = 2; push = 1'b1; end
                2: begin
                    if (key == refKey) begin
                        stable++;
                        if (stable >= LF) expState = 3;
                    end else begin
                        refKey = key; stable = 1;
                    end
                    push = 1'b1;
                end
                default: begin
                    if (key != refKey) begin refKey = key; stable = 1; expState = 2; end
                    push = 1'b1;
                end
            endcase
        end
        m.lk = (expState == 3);
        if (push) measQ.push_back(m);
        curSum = '0;
        sofPending = 1'b1;
    endtask

    task automatic applyStimulus(input int hact, input int nLines, input int rstLine);
        logic [15:0] rgb;
        bit active;
        pix_t p;
        for (int l = 0; l < nLines; l++) begin
            for (int c = 0; c < HT; c++) begin
                if (l == 0 && c == 0) modelVsEdge();
                if (c == 0) lastHsCyc = cyc;
                LCD_HSYNC = (c < 4) ? 1'b0 : 1'b1;
                LCD_VSYNC = (l < 2) ? 1'b0 : 1'b1;
                active = (l >= VSTART) && (l < VSTART + VA) && (c >= DS) && (c < DS + hact);
                rgb = 16'($urandom);
                {LCD_R, LCD_G, LCD_B} = rgb;
                LCD_DE = active;
                if (active) begin
                    curSum += rgb;
                    curHact = hact;
                    if (expState != 0) begin
                        p.data = rgb; p.sof = sofPending; p.eol = (c == DS + hact - 1);
                        p.at = cyc + 2;
                        sofPending = 1'b0;
                        pixQ.push_back(p);
                    end
                end
                if (l == rstLine && c == 36) RST = 1'b1;
                @(posedge PixelClk); #1;
                if (RST) begin
                    RST = 1'b0;
                    checkZero("midReset");
                    expState = 0; stable = 0; stale = 1'b0; curSum = '0;
                end
            end
        end
    endtask

    task automatic idleCycles(input int n);
        LCD_DE = 1'b0; LCD_HSYNC = 1'b1; LCD_VSYNC = 1'b1;
        repeat (n) begin @(posedge PixelClk); #1; end
    endtask

    // Pixel and measurement scoreboards, sampled away from the active edge
    always @(negedge PixelClk) begin
        if (monOn) begin
            if (PIX_VALID === 1'b1) begin
                if (pixQ.size() == 0) begin
                    checkOutput("pixUnexpected", 1, 0);
                end else begin
                    pix_t p;
                    p = pixQ.pop_front();
                    checkOutput("pixData", 32'(PIX_DATA), 32'(p.data));
                    checkOutput("pixSof", 32'(PIX_SOF), 32'(p.sof));
                    checkOutput("pixEol", 32'(PIX_EOL), 32'(p.eol));
                    checkOutput("pixCycle", 32'(cyc), 32'(p.at));
                end
            end else if (PIX_SOF !== 1'b0 || PIX_EOL !== 1'b0) begin
                checkOutput("pixStrayMarker", 32'({PIX_SOF, PIX_EOL}), 0);
            end
            if (MEAS_VALID === 1'b1) begin
                if (measQ.size() == 0) begin
                    checkOutput("measUnexpected", 1, 0);
                end else begin
                    meas_t m;
                    m = measQ.pop_front();
                    checkOutput("hTotal", 32'(H_TOTAL), 32'(m.ht));
                    checkOutput("hActive", 32'(H_ACTIVE), 32'(m.ha));
                    checkOutput("vTotal", 32'(V_TOTAL), 32'(m.vt));
                    checkOutput("vActive", 32'(V_ACTIVE), 32'(m.va));
                    checkOutput("frameSum", 32'(FRAME_SUM), 32'(m.sum));
                    checkOutput("locked", 32'(LOCKED), 32'(m.lk));
                    checkOutput("measCycle", 32'(cyc), 32'(m.at));
                end
            end
        end
    end

    initial begin
        int dropCyc;
        RST = 1'b1; LCD_DE = 1'b0; LCD_HSYNC = 1'b1; LCD_VSYNC = 1'b1;
        {LCD_R, LCD_G, LCD_B} = 16'h0;
        repeat (3) begin @(posedge PixelClk); #1; end
        checkZero("reset");
        RST = 1'b0;
        monOn = 1'b1;
        idleCycles(5);

        repeat (6) applyStimulus(24, VT, -1);
        applyStimulus(25, VT, -1);
        repeat (4) applyStimulus(24, VT, -1);

        idleCycles(1);
        dropCyc = -1;
        repeat (TMO + 60) begin
            if (dropCyc < 0 && LOCKED === 1'b0) dropCyc = cyc;
            @(posedge PixelClk); #1;
        end
        expState = 0; stable = 0; stale = 1'b1; curSum = '0;
        checkOutput("timeoutDropCycle", 32'(dropCyc), 32'(lastHsCyc + TMO + 3));
        checkOutput("lockedAfterTimeout", 32'(LOCKED), 0);
        checkOutput("pixValidAfterTimeout", 32'(PIX_VALID), 0);
        checkOutput("hActiveHeld", 32'(H_ACTIVE), 24);

        repeat (5) applyStimulus(24, VT, -1);
        applyStimulus(24, VT, 5);
        repeat (3) applyStimulus(24, VT, -1);
        applyStimulus(24, 1, -1);
        idleCycles(10);

        checkOutput("pixQueueDrained", 32'(pixQ.size()), 0);
        checkOutput("measQueueDrained", 32'(measQ.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
